// File: rtl/switch_alloc_3port.sv
// Registered wormhole switch allocator for the 3-port router: one round-robin
// IDLE/LOCKED FSM per output port, each lock held until the owner's tail advances.
module switch_alloc_3port (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_x,
    input  logic       valid_y,
    input  logic       valid_local,
    input  logic [1:0] route_x,
    input  logic [1:0] route_y,
    input  logic [1:0] route_local,
    input  logic       tail_x,
    input  logic       tail_y,
    input  logic       tail_local,
    input  logic       en_x,
    input  logic       en_y,
    input  logic       en_local,
    output logic [2:0] out_x_sw,
    output logic [2:0] out_y_sw,
    output logic [2:0] out_local_sw,
    output logic       err
);
    localparam logic [2:0] SW_IDLE  = 3'b000;
    localparam logic [2:0] SW_X1    = 3'b001;
    localparam logic [2:0] SW_Y1    = 3'b010;
    localparam logic [2:0] SW_LOCAL = 3'b100;

    typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

    // Index 3 is a permanently-idle dummy so 2-bit owner/candidate indices stay in range.
    logic [3:0] valid_v, tail_v, en_v;
    logic [1:0] route_v [3];

    // state_q is the per-output FSM state; checkers bind to it directly.
    state_t     state_q  [3];
    state_t     state_d  [3];
    logic [1:0] owner_q  [3];
    logic [1:0] owner_d  [3];
    logic [1:0] rr_ptr_q [3];
    logic [1:0] rr_ptr_d [3];
    logic [2:0] sel_q    [3];
    logic [2:0] sel_d    [3];
    logic       err_q, err_d;

    logic [3:0] busy;
    logic [3:0] taken;
    logic [3:0] req [3];
    logic [2:0] sum;
    logic [1:0] cand;
    logic       hit;

    assign valid_v    = {1'b0, valid_local, valid_y, valid_x};
    assign tail_v     = {1'b0, tail_local, tail_y, tail_x};
    assign en_v       = {1'b0, en_local, en_y, en_x};
    assign route_v[0] = route_x;
    assign route_v[1] = route_y;
    assign route_v[2] = route_local;

    function automatic logic [2:0] sel_code(input logic [1:0] idx);
        case (idx)
            2'd0:    return SW_X1;
            2'd1:    return SW_Y1;
            default: return SW_LOCAL;
        endcase
    endfunction

    always_comb begin
        busy  = '0;
        taken = '0;
        sum   = '0;
        cand  = '0;
        hit   = 1'b0;
        err_d = err_q;
        for (int o = 0; o < 3; o++) begin
            if (state_q[o] == ST_LOCKED) busy[owner_q[o]] = 1'b1;
        end
        // Route 3 and U-turns are never requests; they only raise the sticky error.
        for (int i = 0; i < 3; i++) begin
            if (valid_v[i] && (route_v[i] == 2'd3 || route_v[i] == 2'(i))) err_d = 1'b1;
        end
        for (int o = 0; o < 3; o++) begin
            req[o] = '0;
            for (int i = 0; i < 3; i++) begin
                req[o][i] = valid_v[i] && (route_v[i] == 2'(o)) && (o != i) && !busy[i];
            end
        end
        // Outputs are served in index order so a lower output claims a contested input first.
        for (int o = 0; o < 3; o++) begin
            state_d[o]  = state_q[o];
            owner_d[o]  = owner_q[o];
            rr_ptr_d[o] = rr_ptr_q[o];
            sel_d[o]    = sel_q[o];
            hit         = 1'b0;
            case (state_q[o])
                ST_LOCKED: begin
                    if (valid_v[owner_q[o]] && en_v[owner_q[o]] && tail_v[owner_q[o]]) begin
                        state_d[o] = ST_IDLE;
                        sel_d[o]   = SW_IDLE;
                    end
                end
                default: begin
                    for (int k = 0; k < 3; k++) begin
                        sum  = {1'b0, rr_ptr_q[o]} + 3'(k);
                        cand = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
                        if (!hit && req[o][cand] && !taken[cand]) begin
                            hit         = 1'b1;
                            taken[cand] = 1'b1;
                            state_d[o]  = ST_LOCKED;
                            owner_d[o]  = cand;
                            sel_d[o]    = sel_code(cand);
                            rr_ptr_d[o] = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int o = 0; o < 3; o++) begin
                state_q[o]  <= ST_IDLE;
                owner_q[o]  <= '0;
                rr_ptr_q[o] <= '0;
                sel_q[o]    <= SW_IDLE;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < 3; o++) begin
                state_q[o]  <= state_d[o];
                owner_q[o]  <= owner_d[o];
                rr_ptr_q[o] <= rr_ptr_d[o];
                sel_q[o]    <= sel_d[o];
            end
            err_q <= err_d;
        end
    end

    assign out_x_sw     = sel_q[0];
    assign out_y_sw     = sel_q[1];
    assign out_local_sw = sel_q[2];
    assign err          = err_q;

endmodule

// File: tb/tb_switch_alloc_3port.sv
// Bench for switch_alloc_3port: per-input flit sources, a packet-level allocation
// model that acts as flow control, and a monitor comparing every registered output.
module tb_switch_alloc_3port;
    localparam logic [2:0] SW_X1    = 3'b001;
    localparam logic [2:0] SW_Y1    = 3'b010;
    localparam logic [2:0] SW_LOCAL = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_x, valid_y, valid_local;
    logic [1:0] route_x, route_y, route_local;
    logic       tail_x, tail_y, tail_local;
    logic       en_x, en_y, en_local;
    logic [2:0] out_x_sw, out_y_sw, out_local_sw;
    logic       err;

    always #5 clk = ~clk;

    switch_alloc_3port dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_x      (valid_x),
        .valid_y      (valid_y),
        .valid_local  (valid_local),
        .route_x      (route_x),
        .route_y      (route_y),
        .route_local  (route_local),
        .tail_x       (tail_x),
        .tail_y       (tail_y),
        .tail_local   (tail_local),
        .en_x         (en_x),
        .en_y         (en_y),
        .en_local     (en_local),
        .out_x_sw     (out_x_sw),
        .out_y_sw     (out_y_sw),
        .out_local_sw (out_local_sw),
        .err          (err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_exp;

    // Flit sources per input: {route[1:0], tail}
    logic [2:0] src0[$];
    logic [2:0] src1[$];
    logic [2:0] src2[$];

    // Reference model: owner of each output (-1 = free), round-robin start, error flag
    int m_owner[3];
    int m_ptr[3];
    bit m_err;
    int en_pct;
    bit en_off[3];

    function automatic int src_size(int i);
        case (i)
            0:       return src0.size();
            1:       return src1.size();
            default: return src2.size();
        endcase
    endfunction

    function automatic logic [2:0] src_head(int i);
        if (src_size(i) == 0) return 3'b000;
        case (i)
            0:       return src0[0];
            1:       return src1[0];
            default: return src2[0];
        endcase
    endfunction

    task automatic src_pop(int i);
        case (i)
            0:       void'(src0.pop_front());
            1:       void'(src1.pop_front());
            default: void'(src2.pop_front());
        endcase
    endtask

    task automatic src_clear(int i);
        case (i)
            0:       src0.delete();
            1:       src1.delete();
            default: src2.delete();
        endcase
    endtask

    task automatic push_pkt(int i, int route, int len);
        logic [2:0] f;
        for (int k = 0; k < len; k++) begin
            f = {2'(route), (k == len - 1) ? 1'b1 : 1'b0};
            case (i)
                0:       src0.push_back(f);
                1:       src1.push_back(f);
                default: src2.push_back(f);
            endcase
        end
    endtask

    function automatic logic [2:0] code_of(int own);
        if (own == 0) return SW_X1;
        if (own == 1) return SW_Y1;
        if (own == 2) return SW_LOCAL;
        return 3'b000;
    endfunction

    // One clock: drive the heads of the sources, advance the model, queue the expected outputs.
    task automatic cycle();
        bit         v[3];
        int         r[3];
        bit         t[3];
        bit         e[3];
        bit         busy[3];
        int         nxt[3];
        int         own;
        int         cand;
        logic [2:0] f;
        for (int i = 0; i < 3; i++) begin
            f    = src_head(i);
            v[i] = (src_size(i) > 0);
            r[i] = int'(f[2:1]);
            t[i] = f[0];
            e[i] = en_off[i] ? 1'b0 : ($urandom_range(0, 99) < en_pct);
        end
        valid_x = v[0]; route_x = 2'(r[0]); tail_x = t[0]; en_x = e[0];
        valid_y = v[1]; route_y = 2'(r[1]); tail_y = t[1]; en_y = e[1];
        valid_local = v[2]; route_local = 2'(r[2]); tail_local = t[2]; en_local = e[2];

        if (!rst_n) begin
            for (int o = 0; o < 3; o++) begin
                m_owner[o] = -1;
                m_ptr[o]   = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) busy[i] = 1'b0;
            for (int o = 0; o < 3; o++) if (m_owner[o] >= 0) busy[m_owner[o]] = 1'b1;
            for (int i = 0; i < 3; i++) if (v[i] && (r[i] == 3 || r[i] == i)) m_err = 1'b1;
            for (int o = 0; o < 3; o++) begin
                nxt[o] = m_owner[o];
                if (m_owner[o] >= 0) begin
                    own = m_owner[o];
                    if (v[own] && e[own] && t[own]) nxt[o] = -1;
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        cand = (m_ptr[o] + k) % 3;
                        if (nxt[o] < 0 && v[cand] && r[cand] == o && cand != o && !busy[cand]) begin
                            nxt[o]   = cand;
                            m_ptr[o] = (cand + 1) % 3;
                        end
                    end
                end
            end
            for (int o = 0; o < 3; o++) begin
                own = m_owner[o];
                if (own >= 0 && v[own] && e[own]) src_pop(own);
            end
            for (int o = 0; o < 3; o++) m_owner[o] = nxt[o];
        end
        exp_q.push_back({m_err, code_of(m_owner[2]), code_of(m_owner[1]), code_of(m_owner[0])});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(string name, logic [2:0] act, logic [2:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check("out_x_sw", out_x_sw, mon_exp[2:0]);
            check("out_y_sw", out_y_sw, mon_exp[5:3]);
            check("out_local_sw", out_local_sw, mon_exp[8:6]);
            check("err", {2'b00, err}, {2'b00, mon_exp[9]});
        end
    end

    initial begin
        int guard;
        rst_n  = 1'b0;
        en_pct = 100;
        for (int o = 0; o < 3; o++) begin
            en_off[o]  = 1'b0;
            m_owner[o] = -1;
            m_ptr[o]   = 0;
        end
        m_err = 1'b0;
        repeat (2) cycle();
        rst_n = 1'b1;

        // Local -> X, three flits
        push_pkt(2, 0, 3);
        repeat (6) cycle();

        // Y and local contend for X with single-flit packets
        for (int k = 0; k < 4; k++) begin
            push_pkt(1, 0, 1);
            push_pkt(2, 0, 1);
        end
        repeat (20) cycle();

        // X owns local while its tail is stalled
        push_pkt(0, 2, 1);
        en_off[0] = 1'b1;
        repeat (12) cycle();
        en_off[0] = 1'b0;
        repeat (4) cycle();

        // Three disjoint grants in one cycle
        push_pkt(0, 1, 2);
        push_pkt(1, 2, 2);
        push_pkt(2, 0, 2);
        repeat (5) cycle();

        // U-turn, then route 3; each cleared by a one-cycle reset
        push_pkt(0, 0, 1);
        repeat (2) cycle();
        src_clear(0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        push_pkt(1, 3, 1);
        repeat (2) cycle();
        src_clear(1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Reset while Y holds X on flit 2 of 4 and local waits
        push_pkt(1, 0, 4);
        push_pkt(2, 0, 2);
        repeat (2) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        repeat (14) cycle();

        // Random traffic with random backpressure
        en_pct = 70;
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                if (src_size(i) < 2 && $urandom_range(0, 3) == 0)
                    push_pkt(i, (i + 1 + int'($urandom_range(0, 1))) % 3, int'($urandom_range(1, 4)));
            end
            cycle();
        end

        en_pct = 100;
        guard  = 0;
        while ((src_size(0) + src_size(1) + src_size(2) > 0 ||
                m_owner[0] >= 0 || m_owner[1] >= 0 || m_owner[2] >= 0) && guard < 200) begin
            cycle();
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: traffic still pending after %0d cycles, expected idle", guard);
        end
        repeat (2) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
